// File: rtl/int8_requant.sv
// Three-stage int32 -> int8 requantizer: bias add, unsigned fixed-point scale,
// round-half-up arithmetic shift, optional ReLU and int8 saturation, with valid/ready flow.
module int8_requant #(
  parameter int SATCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_acc,
  input  logic [31:0]         in_bias,
  input  logic [15:0]         in_scale,
  input  logic [4:0]          in_shift,
  input  logic                in_relu,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_sat,
  output logic                out_last,
  output logic [SATCNT_W-1:0] sat_count
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 16;
  localparam int STAGES = 3;
  localparam int PROD_W = DATA_W + COEF_W + 2;

  localparam logic signed [PROD_W-1:0] ONE  = PROD_W'(1);
  localparam logic signed [PROD_W-1:0] MAXV = PROD_W'(127);
  localparam logic signed [PROD_W-1:0] MINV = -PROD_W'(128);

  logic                      vld_p0, vld_p1, vld_p2;
  logic                      adv_p0, adv_p1, adv_p2;
  logic [STAGES-1:0]         vld_all;

  logic signed [DATA_W:0]    sum_p0;
  logic [COEF_W-1:0]         scale_p0;
  logic [4:0]                shift_p0, shift_p1;
  logic                      relu_p0, relu_p1;
  logic                      last_p0, last_p1;
  logic signed [PROD_W-1:0]  prod_p1;
  logic [7:0]                data_p2;
  logic                      sat_p2, last_p2;

  function automatic logic signed [PROD_W-1:0] mul_scale(
    input logic signed [DATA_W:0] s,
    input logic [COEF_W-1:0]      m
  );
    logic signed [PROD_W-1:0] se, me;
    se = PROD_W'(s);
    me = $signed(PROD_W'(m));
    return se * me;
  endfunction

  // Half toward +inf: add half an LSB of the result, then floor via arithmetic shift.
  function automatic logic signed [PROD_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p,
    input logic [4:0]               sh
  );
    logic signed [PROD_W-1:0] rnd;
    rnd = (sh == 5'd0) ? '0 : (ONE <<< (sh - 5'd1));
    return (p + rnd) >>> sh;
  endfunction

  // Returns {sat, data}; a ReLU clamp to zero is not counted as saturation.
  function automatic logic [8:0] sat_relu(
    input logic signed [PROD_W-1:0] r,
    input logic                     relu
  );
    logic signed [PROD_W-1:0] v;
    v = (relu && r[PROD_W-1]) ? '0 : r;
    if (v > MAXV)      return {1'b1, 8'h7f};
    else if (v < MINV) return {1'b1, 8'h80};
    else               return {1'b0, v[7:0]};
  endfunction

  assign vld_all  = {vld_p2, vld_p1, vld_p0};
  assign adv_p2   = !vld_all[2] || out_ready;
  assign adv_p1   = !vld_all[1] || adv_p2;
  assign adv_p0   = !vld_all[0] || adv_p1;
  assign in_ready = !rst && adv_p0;

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_sat   = sat_p2;
  assign out_last  = last_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      data_p2   <= '0;
      sat_p2    <= 1'b0;
      last_p2   <= 1'b0;
      sat_count <= '0;
    end else begin
      if (adv_p0) vld_p0 <= in_valid;
      if (adv_p1) vld_p1 <= vld_p0;
      // p1 -> p2: round, clamp, saturate into the output registers
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          {sat_p2, data_p2} <= sat_relu(round_shift(prod_p1, shift_p1), relu_p1);
          last_p2           <= last_p1;
        end
      end
      if (out_valid && out_ready && sat_p2 && (sat_count != '1))
        sat_count <= sat_count + SATCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // input -> p0: 33-bit bias add
    if (adv_p0 && in_valid) begin
      sum_p0   <= $signed({in_acc[31], in_acc}) + $signed({in_bias[31], in_bias});
      scale_p0 <= in_scale;
      shift_p0 <= in_shift;
      relu_p0  <= in_relu;
      last_p0  <= in_last;
    end
    // p0 -> p1: scale by zero-extended multiplier
    if (adv_p1 && vld_p0) begin
      prod_p1  <= mul_scale(sum_p0, scale_p0);
      shift_p1 <= shift_p0;
      relu_p1  <= relu_p0;
      last_p1  <= last_p0;
    end
  end

endmodule

// File: tb/tb_int8_requant.sv
// Scoreboard bench for int8_requant: directed cases plus randomized traffic with
// random backpressure, checked against an arithmetic reference model.
module tb_int8_requant;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_acc, in_bias;
  logic [15:0]   in_scale;
  logic [4:0]    in_shift;
  logic          in_relu, in_last;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;
  logic          out_sat, out_last;
  logic [CW-1:0] sat_count;

  typedef struct {
    logic signed [7:0] d;
    logic              s;
    logic              l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt   = 0;
  bit   rnd_on = 0;
  bit   saw_low;

  int8_requant #(.SATCNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .in_bias(in_bias), .in_scale(in_scale), .in_shift(in_shift),
    .in_relu(in_relu), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_last(out_last), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic on 64-bit values, floor division for the shift.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [15:0] m,
                                 input logic [4:0] sh, input logic relu, input logic last);
    longint s, p, r, one;
    exp_t   e;
    s   = longint'($signed(a)) + longint'($signed(b));
    p   = s * longint'({48'd0, m});
    one = 1;
    r   = p;
    if (sh != 5'd0) r = r + (one << (int'(sh) - 1));
    r = r >>> sh;
    if (relu && r < 0) r = 0;
    e.s = (r > 127) || (r < -128);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    e.d = 8'(r);
    e.l = last;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", in_ready, 0);
      q.delete();
      mcnt = 0;
    end else begin
      chk("in_ready", in_ready, (q.size() < 3) || out_ready);
      chk("sat_count", sat_count, mcnt);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          chk("out_data", $signed(out_data), q[0].d);
          chk("out_sat", out_sat, q[0].s);
          chk("out_last", out_last, q[0].l);
          if (out_ready) begin
            if (q[0].s && mcnt < CMAX) mcnt++;
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(in_acc, in_bias, in_scale, in_shift, in_relu, in_last));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int acc, input int bias, input int scale, input int shift,
                      input bit relu, input bit last);
    int n;
    in_acc   = acc;
    in_bias  = bias;
    in_scale = 16'(scale);
    in_shift = 5'(shift);
    in_relu  = relu;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
    step();
  endtask

  task automatic lat_check(input string name);
    @(negedge clk);
    chk({name, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_lat2"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_lat3"}, out_valid, 1);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_acc = '0; in_bias = '0; in_scale = '0;
    in_shift = '0; in_relu = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    step();

    send(300, 20, 3, 3, 0, 0);
    lat_check("basic");
    send(-5, 0, 1, 1, 0, 0);
    send(-3, 0, 1, 1, 0, 0);
    send(5, 0, 1, 1, 0, 0);
    send(7, 0, 1, 0, 0, 0);
    send(1000, 0, 1, 0, 0, 0);
    send(-200, 0, 1, 0, 0, 0);
    send(-200, 0, 1, 0, 1, 0);
    send(32'h7fffffff, 32'h7fffffff, 16'hffff, 31, 0, 0);
    send(32'h7fffffff, 32'h7fffffff, 1, 31, 0, 1);
    drain();
    chk("sat_count_directed", sat_count, 3);

    saw_low = 0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i, 0, 1, 0, 0, i == 8);
      end
      begin
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1;
        end
      end
    join
    chk("bp_in_ready_dropped", saw_low, 1);
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1000, 0, 1, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sat_count", sat_count, 0);
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_output", out_valid, 0);
    end
    step();
    send(4, 0, 1, 0, 0, 1);
    lat_check("post_rst");
    drain();

    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int a, b, m, sh;
          if ($urandom_range(0, 3) == 0) step();
          a  = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
          b  = $urandom_range(0, 2) == 0 ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
          m  = $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 4));
          sh = $urandom_range(0, 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
          send(a, b, m, sh, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          step();
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("final_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
